// File: rtl/morse_pkg.sv
// Shared Morse definitions: FSM states, timing units and the
// character lookup table used by the encoder and the decoder.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        SYM_GAP,
        CHAR_GAP,
        WORD_GAP
    } state_t;

    localparam logic [2:0] DOT_U      = 3'd1;
    localparam logic [2:0] DASH_U     = 3'd3;
    localparam logic [2:0] SYM_GAP_U  = 3'd1;
    localparam logic [2:0] CHAR_GAP_U = 3'd3;
    localparam logic [2:0] SPACE_U    = 3'd4;
    localparam logic [4:0] CODE_SPACE = 5'd26;
    localparam logic [2:0] IDX_SPACE  = 3'b101;

    // Returns {valid, index[2:0], data[5:0]}; data is MSB-first from
    // bit index down to bit 0, 1 = dash. Space is valid with no symbols.
    function automatic logic [9:0] morse_lut(input logic [4:0] code);
        logic [9:0] r;
        case (code)
            5'd0:    r = {1'b1, 3'd1, 6'b000001}; // A .-
            5'd1:    r = {1'b1, 3'd3, 6'b001000}; // B -...
            5'd2:    r = {1'b1, 3'd3, 6'b001010}; // C -.-.
            5'd3:    r = {1'b1, 3'd2, 6'b000100}; // D -..
            5'd4:    r = {1'b1, 3'd0, 6'b000000}; // E .
            5'd5:    r = {1'b1, 3'd3, 6'b000010}; // F ..-.
            5'd6:    r = {1'b1, 3'd2, 6'b000110}; // G --.
            5'd7:    r = {1'b1, 3'd3, 6'b000000}; // H ....
            5'd8:    r = {1'b1, 3'd1, 6'b000000}; // I ..
            5'd9:    r = {1'b1, 3'd3, 6'b000111}; // J .---
            5'd10:   r = {1'b1, 3'd2, 6'b000101}; // K -.-
            5'd11:   r = {1'b1, 3'd3, 6'b000100}; // L .-..
            5'd12:   r = {1'b1, 3'd1, 6'b000011}; // M --
            5'd13:   r = {1'b1, 3'd1, 6'b000010}; // N -.
            5'd14:   r = {1'b1, 3'd2, 6'b000111}; // O ---
            5'd15:   r = {1'b1, 3'd3, 6'b000110}; // P .--.
            5'd16:   r = {1'b1, 3'd3, 6'b001101}; // Q --.-
            5'd17:   r = {1'b1, 3'd2, 6'b000010}; // R .-.
            5'd18:   r = {1'b1, 3'd2, 6'b000000}; // S ...
            5'd19:   r = {1'b1, 3'd0, 6'b000001}; // T -
            5'd20:   r = {1'b1, 3'd2, 6'b000001}; // U ..-
            5'd21:   r = {1'b1, 3'd3, 6'b000001}; // V ...-
            5'd22:   r = {1'b1, 3'd2, 6'b000011}; // W .--
            5'd23:   r = {1'b1, 3'd3, 6'b001001}; // X -..-
            5'd24:   r = {1'b1, 3'd3, 6'b001011}; // Y -.--
            5'd25:   r = {1'b1, 3'd3, 6'b001100}; // Z --..
            5'd26:   r = {1'b1, IDX_SPACE, 6'b000000};
            default: r = 10'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Morse time-unit timer: counts 0..UNIT_CYCLES-1 and ticks on wrap.
// Ports: clk_100Mhz, reset (sync, high), clear (restart at 0), tick.
module morse_unit_timer #(
    parameter int UNIT_CYCLES = 10_000_000
) (
    input  logic clk_100Mhz,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = $clog2(UNIT_CYCLES);
    localparam logic [W-1:0] LAST = W'(UNIT_CYCLES - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk_100Mhz) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/morse_encoder.sv
// Character-to-Morse keyer: one A-Z/space code per handshake, keys
// key_out with Morse timing and reports {tx_index, tx_data}.
// Ports: clk_100Mhz, reset (sync, high), char_valid/char_code in,
// char_ready, key_out, busy, err, tx_valid, tx_index, tx_data out.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 10_000_000
) (
    input  logic       clk_100Mhz,
    input  logic       reset,
    input  logic       char_valid,
    input  logic [4:0] char_code,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic       err,
    output logic       tx_valid,
    output logic [2:0] tx_index,
    output logic [5:0] tx_data
);

    state_t     state, state_n;
    logic [2:0] unit_cnt;
    logic [2:0] sym_cnt;
    logic [5:0] shreg;
    logic [2:0] dur;
    logic       tick;
    logic       clear;
    logic       done;
    logic       accept;
    logic [9:0] lut;
    logic       lut_valid;

    assign lut       = morse_lut(char_code);
    assign lut_valid = lut[9];
    assign accept    = char_valid && (state == IDLE);

    assign char_ready = (state == IDLE);
    assign busy       = (state != IDLE);
    assign key_out    = (state == MARK);

    // Restart the unit timer on every state entry so that durations
    // are counted from the entry edge, not a free-running phase.
    assign clear = (state_n != state) || (state == IDLE);

    morse_unit_timer #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_timer (
        .clk_100Mhz(clk_100Mhz),
        .reset     (reset),
        .clear     (clear),
        .tick      (tick)
    );

    // The current symbol always sits in shreg[5].
    always_comb begin
        dur = DOT_U;
        unique case (state)
            MARK:     dur = shreg[5] ? DASH_U : DOT_U;
            SYM_GAP:  dur = SYM_GAP_U;
            CHAR_GAP: dur = CHAR_GAP_U;
            WORD_GAP: dur = SPACE_U;
            default:  dur = DOT_U;
        endcase
    end

    assign done = tick && (unit_cnt == dur - 3'd1);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (char_code == CODE_SPACE) begin
                        state_n = WORD_GAP;
                    end else if (lut_valid) begin
                        state_n = MARK;
                    end
                end
            end
            MARK: begin
                if (done) begin
                    state_n = (sym_cnt == 3'd0) ? CHAR_GAP : SYM_GAP;
                end
            end
            SYM_GAP: begin
                if (done) state_n = MARK;
            end
            CHAR_GAP, WORD_GAP: begin
                if (done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mhz) begin
        if (reset) begin
            state    <= IDLE;
            unit_cnt <= 3'd0;
            sym_cnt  <= 3'd0;
            shreg    <= 6'd0;
            err      <= 1'b0;
            tx_valid <= 1'b0;
            tx_index <= 3'd0;
            tx_data  <= 6'd0;
        end else begin
            state    <= state_n;
            err      <= accept && !lut_valid;
            tx_valid <= done &&
                        ((state == CHAR_GAP) || (state == WORD_GAP));

            if (clear) begin
                unit_cnt <= 3'd0;
            end else if (tick) begin
                unit_cnt <= unit_cnt + 3'd1;
            end

            if (accept && lut_valid) begin
                tx_index <= lut[8:6];
                tx_data  <= lut[5:0];
                // Left-align so the first symbol lands in bit 5.
                shreg    <= lut[5:0] << (3'd5 - lut[8:6]);
                sym_cnt  <= lut[8:6];
            end else if ((state == SYM_GAP) && done) begin
                shreg    <= shreg << 1;
                sym_cnt  <= sym_cnt - 3'd1;
            end
        end
    end

endmodule
